// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: 4-bit parallel-in / serial-out transmit controller.
// Frame = start bit (0), four data bits LSB first, stop bit (1); every bit
// is held for BIT_CYCLES clk cycles. tx idles high.
//
// Handshake: a word is accepted on a rising clk edge where valid=1 and
// ready=1. ready is high only in IDLE while reset is released; valid seen
// while busy is ignored and nothing is queued.
module piso_tx_ctrl #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [3:0] content
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bit-period counter width; at least one bit even when BIT_CYCLES is 1.
  localparam int unsigned   CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    bit_cnt;
  logic [1:0]    bit_n;
  logic [3:0]    sr;
  logic [3:0]    sr_n;
  logic          accept;
  logic          period_end;

  // ready is decoded from the state register and gated by reset so that a
  // word can be accepted on the very first edge after reset release.
  assign ready      = (state == IDLE) && reset;
  assign accept     = valid && ready;
  assign period_end = (cnt == LAST);
  assign content    = sr;

  // Next-state, counter and shift-register decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sr_n    = sr;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          sr_n    = data_in;
          cnt_n   = '0;
          bit_n   = 2'd0;
        end
      end
      START: begin
        if (period_end) begin
          state_n = DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (period_end) begin
          cnt_n = '0;
          // Shift right, back-filling with the idle level.
          sr_n  = {1'b1, sr[3:1]};
          if (bit_cnt == 2'd3) begin
            state_n = STOP;
            bit_n   = 2'd0;
          end else begin
            bit_n = bit_cnt + 2'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (period_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        bit_n   = 2'd0;
      end
    endcase
  end

  // State registers; tx, busy and done are registered from the next-state
  // values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= 2'd0;
      sr      <= 4'b1111;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sr      <= sr_n;
      case (state_n)
        START:   tx <= 1'b0;
        DATA:    tx <= sr_n[0];
        default: tx <= 1'b1;
      endcase
      busy    <= (state_n != IDLE);
      done    <= (state_n == STOP) && (cnt_n == LAST);
    end
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: directed bench for piso_tx_ctrl with BIT_CYCLES=4 and
// BIT_CYCLES=1 instances. Expected serial waveforms are hand-computed
// constants, bit k of each vector = frame cycle k.
module tb_piso_tx_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  initial forever #5 clk = ~clk;

  logic [3:0] data_in4 = 4'd0;
  logic       valid4 = 1'b0;
  logic       ready4, tx4, busy4, done4;
  logic [3:0] content4;

  logic [3:0] data_in1 = 4'd0;
  logic       valid1 = 1'b0;
  logic       ready1, tx1, busy1, done1;
  logic [3:0] content1;

  piso_tx_ctrl #(.BIT_CYCLES(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in4),
    .valid   (valid4),
    .ready   (ready4),
    .tx      (tx4),
    .busy    (busy4),
    .done    (done4),
    .content (content4)
  );

  piso_tx_ctrl #(.BIT_CYCLES(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in1),
    .valid   (valid1),
    .ready   (ready1),
    .tx      (tx1),
    .busy    (busy1),
    .done    (done1),
    .content (content1)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a word, confirm ready, let the next edge accept it.
  task automatic start4(input logic [3:0] word);
    data_in4 = word;
    valid4   = 1'b1;
    #1;
    check("ready_before_hs", {31'd0, ready4}, 32'd1);
    @(posedge clk);
  endtask

  // Sample one 24-cycle frame of dut4 at negedges.
  // mode 0: drop valid; mode 1: keep valid, present next_word;
  // mode 2: noise on valid/data_in throughout the frame.
  task automatic capture4(input int mode, input logic [3:0] next_word,
                          output logic [23:0] txv, output logic [23:0] dv,
                          output logic [23:0] bv, output logic rdy_seen);
    rdy_seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      case (mode)
        0: if (k == 0) valid4 = 1'b0;
        1: if (k == 0) data_in4 = next_word;
        default: begin
          valid4   = ((k % 2) == 0) && (k != 23);
          data_in4 = 4'($urandom_range(0, 15));
        end
      endcase
      txv[k]   = tx4;
      dv[k]    = done4;
      bv[k]    = busy4;
      rdy_seen = rdy_seen | ready4;
    end
  endtask

  logic [23:0] txv, dv, bv;
  logic        rdy_seen;
  logic        flag;
  logic [5:0]  txv1, dv1;

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_tx",      {31'd0, tx4},    32'd1);
    check("rst_ready",   {31'd0, ready4}, 32'd0);
    check("rst_busy",    {31'd0, busy4},  32'd0);
    check("rst_done",    {31'd0, done4},  32'd0);
    check("rst_content", {28'd0, content4}, 32'hF);
    check("rst_content1", {28'd0, content1}, 32'hF);
    check("rst_tx1",     {31'd0, tx1},    32'd1);

    // ---- handshake on first edge after release, word 1010 ----
    @(negedge clk);
    reset = 1'b1;
    start4(4'b1010);
    capture4(0, 4'd0, txv, dv, bv, rdy_seen);
    check("f1010_tx",   {8'd0, txv}, 32'hFF0F00);
    check("f1010_done", {8'd0, dv},  32'h800000);
    check("f1010_busy", {8'd0, bv},  32'hFFFFFF);
    check("f1010_rdy",  {31'd0, rdy_seen}, 32'd0);
    @(negedge clk);
    check("post_content", {28'd0, content4}, 32'hF);
    check("post_ready",   {31'd0, ready4}, 32'd1);
    check("post_busy",    {31'd0, busy4},  32'd0);
    check("post_tx",      {31'd0, tx4},    32'd1);
    check("post_done",    {31'd0, done4},  32'd0);

    // ---- back-to-back with valid held: 0001 then 1110 ----
    start4(4'b0001);
    capture4(1, 4'b1110, txv, dv, bv, rdy_seen);
    check("f0001_tx",   {8'd0, txv}, 32'hF000F0);
    check("f0001_done", {8'd0, dv},  32'h800000);
    check("f0001_rdy",  {31'd0, rdy_seen}, 32'd0);
    @(negedge clk);
    check("gap_ready", {31'd0, ready4}, 32'd1);
    check("gap_busy",  {31'd0, busy4},  32'd0);
    check("gap_tx",    {31'd0, tx4},    32'd1);
    @(posedge clk);
    capture4(0, 4'd0, txv, dv, bv, rdy_seen);
    check("f1110_tx",   {8'd0, txv}, 32'hFFFF00);
    check("f1110_done", {8'd0, dv},  32'h800000);
    check("f1110_busy", {8'd0, bv},  32'hFFFFFF);

    // ---- noise on valid/data_in during a 1100 frame ----
    @(negedge clk);
    start4(4'b1100);
    capture4(2, 4'd0, txv, dv, bv, rdy_seen);
    check("f1100_tx",   {8'd0, txv}, 32'hFFF000);
    check("f1100_done", {8'd0, dv},  32'h800000);
    check("f1100_rdy",  {31'd0, rdy_seen}, 32'd0);
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      flag = flag | busy4 | ~tx4;
    end
    check("no_extra_frame", {31'd0, flag}, 32'd0);

    // ---- reset during 2nd data bit of 0110 ----
    start4(4'b0110);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) valid4 = 1'b0;
    end
    check("mid_content", {28'd0, content4}, 32'hB);
    check("mid_tx",      {31'd0, tx4},      32'd1);
    check("mid_busy",    {31'd0, busy4},    32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_tx",      {31'd0, tx4},    32'd1);
    check("abort_content", {28'd0, content4}, 32'hF);
    check("abort_busy",    {31'd0, busy4},  32'd0);
    check("abort_ready",   {31'd0, ready4}, 32'd0);
    check("abort_done",    {31'd0, done4},  32'd0);
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flag = flag | done4 | busy4;
    end
    check("abort_quiet", {31'd0, flag}, 32'd0);
    reset = 1'b1;
    start4(4'b0011);
    capture4(0, 4'd0, txv, dv, bv, rdy_seen);
    check("f0011_tx",   {8'd0, txv}, 32'hF00FF0);
    check("f0011_done", {8'd0, dv},  32'h800000);

    // ---- BIT_CYCLES=1, word 0101 ----
    @(negedge clk);
    data_in1 = 4'b0101;
    valid1   = 1'b1;
    #1;
    check("bc1_ready", {31'd0, ready1}, 32'd1);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) valid1 = 1'b0;
      txv1[k] = tx1;
      dv1[k]  = done1;
    end
    check("bc1_tx",   {26'd0, txv1}, 32'h2A);
    check("bc1_done", {26'd0, dv1},  32'h20);
    @(negedge clk);
    check("bc1_content", {28'd0, content1}, 32'hF);
    check("bc1_busy",    {31'd0, busy1},    32'd0);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 Parameter BIT_CYCLES, default 4, is the number of clk cycles each serial bit is held; legal range 1..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; assertion (0) forces reset state immediately, independent of clk.
REQ-004 data_in  input  4  parallel word to transmit, sampled only on an accepted handshake.
REQ-005 valid  input  1  requester has a word on data_in.
REQ-006 ready  output  1  controller can accept a word this cycle.
REQ-007 tx  output  1  registered serial line, idle high.
REQ-008 busy  output  1  frame in progress (any state other than IDLE).
REQ-009 done  output  1  one-cycle pulse marking the last cycle of a frame.
REQ-010 content  output  4  current internal shift-register contents.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA and STOP, plus an internal 4-bit shift register, a bit-period counter and a 2-bit data-bit counter.
REQ-012 In IDLE the block SHALL drive ready=1, busy=0, tx=1.
REQ-013 A handshake SHALL occur on a rising edge where valid=1 and ready=1; on that edge the shift register SHALL load data_in and the state SHALL go to START.
REQ-014 In START, tx SHALL be 0 for exactly BIT_CYCLES cycles, beginning the cycle after the handshake edge.
REQ-015 In DATA, tx SHALL equal shift register bit 0 (LSB first), each bit held for BIT_CYCLES cycles.
REQ-016 At the end of each data-bit period the shift register SHALL shift right by one, filling bit 3 with 1.
REQ-017 After the 4th data bit the state SHALL go to STOP; the data-bit counter SHALL wrap from 3 to 0 on that transition.
REQ-018 In STOP, tx SHALL be 1 for BIT_CYCLES cycles; done SHALL be 1 only during the final STOP cycle; the next state SHALL be IDLE.
REQ-019 A full frame SHALL last exactly 6*BIT_CYCLES cycles from the first START cycle through the last STOP cycle.
REQ-020 ready SHALL be 0 in START, DATA and STOP; valid asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-021 Changes on data_in after the handshake SHALL NOT affect the frame in progress.
REQ-022 With valid held high continuously, the next handshake SHALL occur on the first IDLE cycle after done, giving a 1-cycle idle gap between frames.
REQ-023 After a complete frame, content SHALL equal 4'b1111.
REQ-024 With BIT_CYCLES=1, each bit SHALL last exactly one cycle and the frame length SHALL be 6 cycles.

Reset
REQ-025 While reset=0 the block SHALL hold state IDLE with tx=1, ready=0, busy=0, done=0, content=4'b1111, and all counters at 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no done pulse; the interrupted word SHALL be discarded.
REQ-027 The first handshake after reset release SHALL occur no earlier than the first rising edge with reset=1, with ready=1 from that cycle.

Verification
REQ-028 BIT_CYCLES=4, send 4'b1010 -> tx = 0x4, 0x4, 1x4, 0x4, 1x4, 1x4 cycles; done at frame cycle 24; content 4'b1111 afterwards.
REQ-029 BIT_CYCLES=4, valid held high, words 4'b0001 then 4'b1110 -> two frames separated by exactly one IDLE cycle with ready=1; LSB-first bit order correct in both frames.
REQ-030 Toggle data_in and pulse valid during a frame -> tx sequence unchanged, ready stays 0, no extra frame is sent.
REQ-031 Assert reset in the 2nd data bit of a frame carrying 4'b0110 -> tx=1 and content=4'b1111 immediately without waiting for a clock edge, no done pulse; next word 4'b0011 transmits correctly.
REQ-032 BIT_CYCLES=1, send 4'b0101 -> tx = 0,1,0,1,0,1 on consecutive cycles; done on the 6th cycle.
REQ-033 Issue a handshake on the first edge after reset release -> START begins on the following cycle.
